// File: rtl/pipeline_ctrl_pkg.sv
// Shared LC-3b pipeline types for the stall/flush sequencer: register index,
// control word, sequencer state and the NOP control word used for bubbles/flushes.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_W  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 16;

    typedef logic [REG_W-1:0]  lc3b_reg;
    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pipe_ctrl_state_t;

    // Latch-input muxes select this when a stage must hold a bubble.
    localparam lc3b_word NOP_CW = WORD_W'(0);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EX.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic    ex_is_load_i,
    input  lc3b_reg ex_dest_i,
    input  lc3b_reg id_src1_i,
    input  lc3b_reg id_src2_i,
    input  logic    id_src1_v_i,
    input  logic    id_src2_v_i,
    output logic    hz_o
);

    always_comb begin
        hz_o = ex_is_load_i &
               ((id_src1_v_i & (id_src1_i == ex_dest_i)) |
                (id_src2_v_i & (id_src2_i == ex_dest_i)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline.
// Optional stall counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [CNT_W-1:0] istall_cnt_o,
    output logic [CNT_W-1:0] dstall_cnt_o,
`endif
    input  logic             imem_resp_i,
    input  logic             dmem_resp_i,
    input  logic             mem_rd_i,
    input  logic             mem_wr_i,
    input  logic             ex_is_load_i,
    input  lc3b_reg          ex_dest_i,
    input  lc3b_reg          id_src1_i,
    input  lc3b_reg          id_src2_i,
    input  logic             id_src1_v_i,
    input  logic             id_src2_v_i,
    input  logic             br_taken_i,
    output logic             imem_read_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic             load_pc_o,
    output logic             load_if_id_o,
    output logic             load_id_ex_o,
    output logic             load_ex_mem_o,
    output logic             load_mem_wb_o,
    output logic             bubble_id_ex_o,
    output logic             flush_o,
    output logic             pcmux_sel_o
);

    pipe_ctrl_state_t st_q, st_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;

    logic dmem_need;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic hz;

    hazard_detect u_hazard_detect (
        .ex_is_load_i (ex_is_load_i),
        .ex_dest_i    (ex_dest_i),
        .id_src1_i    (id_src1_i),
        .id_src2_i    (id_src2_i),
        .id_src1_v_i  (id_src1_v_i),
        .id_src2_v_i  (id_src2_v_i),
        .hz_o         (hz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    // Advance is Mealy so a single-cycle hit costs no extra cycle.
    always_comb begin
        st_d           = st_q;
        i_done_d       = i_done_q;
        d_done_d       = d_done_q;
        imem_read_o    = 1'b0;
        dmem_read_o    = 1'b0;
        dmem_write_o   = 1'b0;
        load_pc_o      = 1'b0;
        load_if_id_o   = 1'b0;
        load_id_ex_o   = 1'b0;
        load_ex_mem_o  = 1'b0;
        load_mem_wb_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        flush_o        = 1'b0;
        pcmux_sel_o    = 1'b0;

        dmem_need = mem_rd_i | mem_wr_i;
        i_ok      = i_done_q | imem_resp_i;
        d_ok      = ~dmem_need | d_done_q | dmem_resp_i;
        advance   = i_ok & d_ok;

        if (advance) begin
            st_d     = RUN;
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end else begin
            case (st_q)
                RUN: begin
                    st_d     = WAIT;
                    i_done_d = imem_resp_i;
                    d_done_d = dmem_need & dmem_resp_i;
                end
                WAIT: begin
                    st_d     = WAIT;
                    i_done_d = i_done_q | imem_resp_i;
                    d_done_d = d_done_q | (dmem_need & dmem_resp_i);
                end
            endcase
        end

        // Completed accesses are not re-issued while the other one is pending.
        if (!reset) begin
            imem_read_o  = ~i_done_q;
            dmem_read_o  = mem_rd_i & ~d_done_q;
            dmem_write_o = mem_wr_i & ~d_done_q;
            if (advance) begin
                load_id_ex_o  = 1'b1;
                load_ex_mem_o = 1'b1;
                load_mem_wb_o = 1'b1;
                if (br_taken_i) begin
                    flush_o      = 1'b1;
                    pcmux_sel_o  = 1'b1;
                    load_pc_o    = 1'b1;
                    load_if_id_o = 1'b1;
                end else if (hz) begin
                    bubble_id_ex_o = 1'b1;
                end else begin
                    load_pc_o    = 1'b1;
                    load_if_id_o = 1'b1;
                end
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    // Saturating stall counters; a D stall is counted only once fetch is satisfied.
    always_ff @(posedge clk) begin
        if (reset) begin
            istall_cnt_o <= '0;
            dstall_cnt_o <= '0;
        end else begin
            if (!advance && !i_ok && (istall_cnt_o != {CNT_W{1'b1}})) begin
                istall_cnt_o <= istall_cnt_o + CNT_W'(1);
            end
            if (!advance && i_ok && !d_ok && (dstall_cnt_o != {CNT_W{1'b1}})) begin
                dstall_cnt_o <= dstall_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed test-plan sequences followed by
// randomized traffic, checked against a rule-level model of the sequencer.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    imem_resp, dmem_resp, mem_rd, mem_wr;
    logic    ex_is_load, id_src1_v, id_src2_v, br_taken;
    lc3b_reg ex_dest, id_src1, id_src2;
    logic    imem_read, dmem_read, dmem_write;
    logic    load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic    bubble_id_ex, flush, pcmux_sel;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    // Model: which of the current step's memory accesses have already completed.
    bit got_i = 1'b0;
    bit got_d = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_resp_i    (imem_resp),
        .dmem_resp_i    (dmem_resp),
        .mem_rd_i       (mem_rd),
        .mem_wr_i       (mem_wr),
        .ex_is_load_i   (ex_is_load),
        .ex_dest_i      (ex_dest),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_src1_v_i    (id_src1_v),
        .id_src2_v_i    (id_src2_v),
        .br_taken_i     (br_taken),
        .imem_read_o    (imem_read),
        .dmem_read_o    (dmem_read),
        .dmem_write_o   (dmem_write),
        .load_pc_o      (load_pc),
        .load_if_id_o   (load_if_id),
        .load_id_ex_o   (load_id_ex),
        .load_ex_mem_o  (load_ex_mem),
        .load_mem_wb_o  (load_mem_wb),
        .bubble_id_ex_o (bubble_id_ex),
        .flush_o        (flush),
        .pcmux_sel_o    (pcmux_sel)
    );

    logic [10:0] act;
    assign act = {imem_read, dmem_read, dmem_write, load_pc, load_if_id, load_id_ex,
                  load_ex_mem, load_mem_wb, bubble_id_ex, flush, pcmux_sel};

    // Monitor: compares every cycle for which the stimulus side queued a prediction.
    initial begin
        logic [10:0] e;
        string       t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s cycle=%0d outputs actual=%b expected=%b (ir dr dw pc ifid idex exmem memwb bub fl pcm)",
                             t, cycle, act, e);
                end
            end
        end
    end

    task automatic step(input bit rst, input bit ir, input bit dr, input bit mr, input bit mw,
                        input bit ld, input bit [2:0] dst, input bit [2:0] s1, input bit [2:0] s2,
                        input bit v1, input bit v2, input bit br, input string tag);
        bit need, fetch_ok, data_ok, go, use_hit;
        bit e_ir, e_dr, e_dw, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_bub, e_fl, e_pcm;
        @(posedge clk);
        #1;
        cycle++;
        reset = rst; imem_resp = ir; dmem_resp = dr; mem_rd = mr; mem_wr = mw;
        ex_is_load = ld; ex_dest = dst; id_src1 = s1; id_src2 = s2;
        id_src1_v = v1; id_src2_v = v2; br_taken = br;

        need     = mr || mw;
        fetch_ok = got_i || ir;
        data_ok  = !need || got_d || dr;
        go       = fetch_ok && data_ok;
        use_hit  = ld && ((v1 && (s1 == dst)) || (v2 && (s2 == dst)));

        {e_ir, e_dr, e_dw, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_bub, e_fl, e_pcm} = '0;
        if (!rst) begin
            e_ir = !got_i;
            e_dr = mr && !got_d;
            e_dw = mw && !got_d;
            if (go) begin
                e_idex = 1; e_exmem = 1; e_memwb = 1;
                if (br) begin
                    e_fl = 1; e_pcm = 1; e_pc = 1; e_ifid = 1;
                end else if (use_hit) begin
                    e_bub = 1;
                end else begin
                    e_pc = 1; e_ifid = 1;
                end
            end
        end
        exp_q.push_back({e_ir, e_dr, e_dw, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_bub, e_fl, e_pcm});
        tag_q.push_back(tag);

        if (rst || go) begin
            got_i = 0;
            got_d = 0;
        end else begin
            got_i = got_i || ir;
            got_d = got_d || (need && dr);
        end
    endtask

    task automatic idle(input bit ir, input string tag);
        step(0, ir, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, tag);
    endtask

    initial begin
        reset = 1; imem_resp = 0; dmem_resp = 0; mem_rd = 0; mem_wr = 0;
        ex_is_load = 0; ex_dest = '0; id_src1 = '0; id_src2 = '0;
        id_src1_v = 0; id_src2_v = 0; br_taken = 0;

        step(1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "reset");
        step(1, 1, 1, 1, 1, 1, 3'd2, 3'd2, 3'd0, 1, 0, 1, "reset_busy");

        for (int i = 0; i < 5; i++) idle(1, "hit_stream");

        for (int i = 0; i < 3; i++) idle(0, "imem_wait");
        idle(1, "imem_late_resp");
        idle(1, "imem_after_wait");

        step(0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_c1");
        step(0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_c2_resp");
        step(0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_c3_sticky");
        step(0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_c4_dup_resp");
        step(0, 1, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_c5_advance");

        step(0, 1, 0, 0, 0, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, "load_use_src1");
        step(0, 1, 0, 0, 0, 1, 3'd5, 3'd1, 3'd5, 0, 1, 0, "load_use_src2");
        step(0, 1, 0, 0, 0, 1, 3'd3, 3'd3, 3'd3, 0, 0, 0, "load_use_invalid_src");
        step(0, 1, 0, 0, 0, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, "branch_over_hazard");
        step(0, 1, 1, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "store_single_cycle");

        step(0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "wait_d_done");
        step(0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "wait_hold");
        step(1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "reset_in_wait");
        step(0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "dmem_read_reissue");
        step(0, 1, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, "both_resp_same_cycle");

        for (int i = 0; i < 2000; i++) begin
            bit rr, mr, mw;
            rr = ($urandom_range(99) < 3);
            mr = ($urandom_range(99) < 25);
            mw = !mr && ($urandom_range(99) < 15);
            step(rr, ($urandom_range(99) < 55), ($urandom_range(99) < 50), mr, mw,
                 $urandom_range(1), 3'($urandom_range(7)), 3'($urandom_range(7)),
                 3'($urandom_range(7)), $urandom_range(1), $urandom_range(1),
                 ($urandom_range(99) < 20), "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
